sqrt_job_sequencer: RTL and testbench

//  Upstream feeder and result collector for the iterative square-root core (odd-number subtraction, 8-bit

---
 rtl/sqrt_pkg.sv | 21 ++
 rtl/sqrt_op_fifo.sv | 74 +++++++
 rtl/sqrt_job_sequencer.sv | 161 ++++++++++++++++
 tb/tb_sqrt_job_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_pkg
// Purpose  : Shared widths and sequencer state encoding for the sqrt job path.
// Revision : 1.0
// ============================================================================
package sqrt_pkg;

    localparam int OPERAND_W = 8;
    localparam int ROOT_W    = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/sqrt_op_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_op_fifo
// Purpose  : Operand FIFO with registered ready/empty; pointers carry a wrap bit.
// Revision : 1.0
// ============================================================================
module sqrt_op_fifo
    import sqrt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = OPERAND_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_ready,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic [c_aw:0]    w_wr_next;
    logic [c_aw:0]    w_rd_next;
    logic             r_ready;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_full_next;
    logic             w_empty_next;

    // Ready comes from a register, so a pop never opens a same-cycle push slot.
    assign w_push = i_push && r_ready;
    assign w_pop  = i_pop && !r_empty;

    always_comb begin
        w_wr_next    = r_wr_ptr + {{c_aw{1'b0}}, w_push};
        w_rd_next    = r_rd_ptr + {{c_aw{1'b0}}, w_pop};
        w_full_next  = (w_wr_next[c_aw] != w_rd_next[c_aw]) &&
                       (w_wr_next[c_aw-1:0] == w_rd_next[c_aw-1:0]);
        w_empty_next = (w_wr_next == w_rd_next);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ready  <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_ready  <= !w_full_next;
            r_empty  <= w_empty_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= i_data;
        end
    end

    assign o_ready = r_ready;
    assign o_empty = r_empty;
    assign o_head  = r_mem[r_rd_ptr[c_aw-1:0]];

endmodule
`default_nettype wire

// File: rtl/sqrt_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_job_sequencer
// Purpose  : Feeds buffered operands to the iterative sqrt core one job at a
//            time and returns {operand, root, err}, aborting hung jobs.
// Revision : 1.0
// ============================================================================
module sqrt_job_sequencer
    import sqrt_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_valid,
    input  logic [OPERAND_W-1:0] op_data,
    output logic                 op_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [OPERAND_W-1:0] res_operand,
    output logic [ROOT_W-1:0]    res_root,
    output logic                 res_err,
    output logic [OPERAND_W-1:0] core_in,
    output logic                 core_go,
    output logic                 core_reset,
    input  logic [ROOT_W-1:0]    core_count,
    input  logic                 core_over,
    output logic                 busy
);

    localparam int c_timer_w = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int c_clr_w   = (CLR_CYCLES < 2) ? 1 : $clog2(CLR_CYCLES);
    localparam logic [c_timer_w-1:0] c_timeout  = c_timer_w'(TIMEOUT);
    localparam logic [c_clr_w-1:0]   c_clr_last = c_clr_w'(CLR_CYCLES - 1);

    seq_state_t             r_state;
    seq_state_t             w_state_next;
    logic [c_clr_w-1:0]     r_clr_cnt;
    logic [c_timer_w-1:0]   r_timer;
    logic                   r_sync1;
    logic                   r_over_s;
    logic                   r_over_seen;
    logic [OPERAND_W-1:0]   r_core_in;
    logic [OPERAND_W-1:0]   r_res_operand;
    logic [ROOT_W-1:0]      r_res_root;
    logic                   r_res_err;
    logic                   w_fifo_empty;
    logic [OPERAND_W-1:0]   w_fifo_head;
    logic                   w_pop;
    logic                   w_over_confirm;
    logic                   w_timeout;

    sqrt_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OPERAND_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (op_valid),
        .i_data  (op_data),
        .i_pop   (w_pop),
        .o_ready (op_ready),
        .o_empty (w_fifo_empty),
        .o_head  (w_fifo_head)
    );

    // A done flag counts only once the synchronised level holds for two WAIT cycles.
    assign w_over_confirm = r_over_s && r_over_seen;
    assign w_timeout      = (r_timer == c_timeout);
    assign w_pop          = (r_state == IDLE) && !w_fifo_empty;
    assign busy           = (r_state != IDLE) || !w_fifo_empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (!w_fifo_empty)                 w_state_next = CLR;
            CLR:     if (r_clr_cnt == c_clr_last)       w_state_next = LAUNCH;
            LAUNCH:                                     w_state_next = WAIT;
            WAIT:    if (w_over_confirm || w_timeout)   w_state_next = DONE;
            DONE:    if (res_ready)                     w_state_next = IDLE;
            default:                                    w_state_next = IDLE;
        endcase
    end

    always_comb begin
        core_reset = 1'b1;
        core_go    = 1'b0;
        res_valid  = 1'b0;
        case (r_state)
            LAUNCH, WAIT: begin
                core_reset = 1'b0;
                core_go    = 1'b1;
            end
            DONE:    res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clr_cnt     <= '0;
            r_timer       <= '0;
            r_sync1       <= 1'b0;
            r_over_s      <= 1'b0;
            r_over_seen   <= 1'b0;
            r_core_in     <= '0;
            r_res_operand <= '0;
            r_res_root    <= '0;
            r_res_err     <= 1'b0;
        end else begin
            r_sync1     <= core_over;
            r_over_s    <= r_sync1;
            r_over_seen <= (r_state == WAIT) && r_over_s;
            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        r_core_in     <= w_fifo_head;
                        r_res_operand <= w_fifo_head;
                        r_clr_cnt     <= '0;
                    end
                end
                CLR: begin
                    if (r_clr_cnt != c_clr_last) begin
                        r_clr_cnt <= r_clr_cnt + c_clr_w'(1);
                    end
                end
                LAUNCH: r_timer <= '0;
                WAIT: begin
                    if (!w_timeout) begin
                        r_timer <= r_timer + c_timer_w'(1);
                    end
                    if (w_over_confirm) begin
                        r_res_root <= core_count;
                        r_res_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_res_root <= '0;
                        r_res_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_in     = r_core_in;
    assign res_operand = r_res_operand;
    assign res_root    = r_res_root;
    assign res_err     = r_res_err;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqrt_job_sequencer
// Purpose  : Directed bench for sqrt_job_sequencer with a delay-programmable core model.
// Revision : 1.0
// ============================================================================
module tb_sqrt_job_sequencer;

    localparam int TIMEOUT = 255;

    typedef struct {
        logic [7:0] op;
        logic [4:0] root;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       op_valid = 1'b0;
    logic [7:0] op_data = 8'd0;
    logic       op_ready;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_operand;
    logic [4:0] res_root;
    logic       res_err;
    logic [7:0] core_in;
    logic       core_go;
    logic       core_reset;
    logic [4:0] core_count;
    logic       core_over;
    logic       busy;

    int   n_checks = 0;
    int   n_fails  = 0;
    exp_t q[$];

    int         model_delay = 3;
    bit         model_never = 1'b0;
    logic       glitch = 1'b0;
    logic       model_over = 1'b0;
    logic [4:0] model_count = 5'd0;
    int         model_cyc = 0;

    sqrt_job_sequencer #(.DEPTH(4), .CLR_CYCLES(2), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_data     (op_data),
        .op_ready    (op_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_operand (res_operand),
        .res_root    (res_root),
        .res_err     (res_err),
        .core_in     (core_in),
        .core_go     (core_go),
        .core_reset  (core_reset),
        .core_count  (core_count),
        .core_over   (core_over),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] isqrt(input logic [7:0] x);
        logic [4:0] r;
        r = 5'd0;
        for (int k = 0; k < 16; k++) begin
            if (k * k <= int'(x)) r = 5'(k);
        end
        return r;
    endfunction

    // Core model: raises over model_delay cycles into a run unless told to hang.
    always @(posedge clk) begin
        if (core_reset) begin
            model_over  <= 1'b0;
            model_count <= 5'd0;
            model_cyc   <= 0;
        end else if (core_go) begin
            model_cyc <= model_cyc + 1;
            if (!model_never && model_cyc == model_delay) begin
                model_over  <= 1'b1;
                model_count <= isqrt(core_in);
            end
        end
    end
    assign core_over  = model_over | glitch;
    assign core_count = model_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset && res_valid && res_ready) begin
            n_checks++;
            assert (q.size() != 0) else begin
                n_fails++;
                $error("FAIL unexpected_result observed=%0d expected=no_result", res_operand);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                check("res_operand", 32'(res_operand), 32'(e.op));
                check("res_root", 32'(res_root), 32'(e.root));
                check("res_err", 32'(res_err), 32'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [7:0] v, input logic [4:0] root, input logic err, input bit enq);
        int n;
        exp_t e;
        n = 0;
        while (!op_ready && n < 2000) begin
            tick();
            n++;
        end
        check("push_ready_wait", 32'(op_ready), 32'd1);
        op_valid = 1'b1;
        op_data  = v;
        tick();
        op_valid = 1'b0;
        if (enq) begin
            e.op = v; e.root = root; e.err = err;
            q.push_back(e);
        end
    endtask

    task automatic wait_sig(input string tag, input int which, input int max_cycles);
        int n;
        logic s;
        n = 0;
        s = (which == 0) ? res_valid : core_go;
        while (!s && n < max_cycles) begin
            tick();
            n++;
            s = (which == 0) ? res_valid : core_go;
        end
        check(tag, 32'(s), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 32'(q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] t1_ops   [5];
        logic [4:0] t1_roots [5];
        logic [7:0] t2_ops   [4];
        logic [4:0] t2_roots [4];
        int         n;
        t1_ops   = '{8'd0, 8'd1, 8'd15, 8'd16, 8'd255};
        t1_roots = '{5'd0, 5'd1, 5'd3, 5'd4, 5'd15};
        t2_ops   = '{8'd4, 8'd9, 8'd25, 8'd36};
        t2_roots = '{5'd2, 5'd3, 5'd5, 5'd6};

        // Reset values
        repeat (3) tick();
        check("rst_op_ready", 32'(op_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_operand", 32'(res_operand), 32'd0);
        check("rst_res_root", 32'(res_root), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);
        check("rst_core_in", 32'(core_in), 32'd0);
        check("rst_core_go", 32'(core_go), 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();
        check("post_rst_op_ready", 32'(op_ready), 32'd1);

        // Back-to-back boundary operands
        res_ready   = 1'b1;
        model_delay = 3;
        for (int i = 0; i < 5; i++) push_op(t1_ops[i], t1_roots[i], 1'b0, 1'b1);
        drain("t1_drain");

        // FIFO fill with consumer stalled
        res_ready = 1'b0;
        push_op(8'd100, 5'd10, 1'b0, 1'b1);
        wait_sig("t2_first_done", 0, 500);
        for (int i = 0; i < 4; i++) push_op(t2_ops[i], t2_roots[i], 1'b0, 1'b1);
        check("t2_full_ready", 32'(op_ready), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
        op_valid = 1'b1;
        op_data  = 8'd49;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_blocked_ready", 32'(op_ready), 32'd0);
        end
        res_ready = 1'b1;
        n = 0;
        while (!op_ready && n < 20) begin
            tick();
            n++;
        end
        check("t2_ready_after_pop", 32'(op_ready), 32'd1);
        tick();
        op_valid = 1'b0;
        q.push_back('{op: 8'd49, root: 5'd7, err: 1'b0});
        drain("t2_drain");

        // Result held stable under backpressure
        res_ready = 1'b0;
        push_op(8'd200, 5'd14, 1'b0, 1'b1);
        wait_sig("t3_valid", 0, 500);
        for (int i = 0; i < 20; i++) begin
            check("t3_hold_valid", 32'(res_valid), 32'd1);
            check("t3_hold_operand", 32'(res_operand), 32'd200);
            check("t3_hold_root", 32'(res_root), 32'd14);
            tick();
        end
        res_ready = 1'b1;
        drain("t3_drain");

        // Hung core: abort after TIMEOUT
        model_never = 1'b1;
        push_op(8'd77, 5'd0, 1'b1, 1'b1);
        wait_sig("t4_go", 1, 50);
        n = 0;
        while (core_go && n < 400) begin
            n++;
            tick();
        end
        check("t4_go_cycles", 32'(n), 32'(TIMEOUT + 2));
        check("t4_valid", 32'(res_valid), 32'd1);
        check("t4_err", 32'(res_err), 32'd1);
        drain("t4_drain");
        model_never = 1'b0;

        // Reset during WAIT discards job and FIFO
        model_delay = 30;
        push_op(8'd81, 5'd9, 1'b0, 1'b0);
        push_op(8'd9, 5'd3, 1'b0, 1'b0);
        wait_sig("t5_go", 1, 50);
        repeat (5) tick();
        reset = 1'b0;
        tick();
        check("t5_core_reset", 32'(core_reset), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_res_valid", 32'(res_valid), 32'd0);
        check("t5_core_go", 32'(core_go), 32'd0);
        check("t5_op_ready", 32'(op_ready), 32'd0);
        reset = 1'b1;
        q.delete();
        repeat (60) tick();
        check("t5_idle_busy", 32'(busy), 32'd0);

        // Single-cycle glitch on over is ignored
        model_delay = 40;
        push_op(8'd144, 5'd12, 1'b0, 1'b1);
        wait_sig("t6_go", 1, 50);
        repeat (10) tick();
        glitch = 1'b1;
        tick();
        glitch = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("t6_no_early_valid", 32'(res_valid), 32'd0);
            tick();
        end
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
